uart_time_reporter: RTL and testbench

- Transmit-side companion to the UART command path. On request, or automatically when the displayed time changes, it snapshots the current time digits and formats them as an ASCII line.
- It streams the line byte-by-byte into the UART transmitter using a start/done handshake.
- It sits between time_sel (digit_h, digit_l, dot) and the uart transmitter inputs (start, tx_data, o_tx_done).

---
 rtl/uart_time_reporter.sv | 155 +++++++++++++++
 tb/tb_uart_time_reporter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_time_reporter.sv
// Formats a snapshot of the displayed time as "HH?LL[CR LF]" and streams it byte-by-byte into
// the UART transmitter using a tx_start/tx_done handshake.
module uart_time_reporter #(
    parameter logic [7:0] SEP_DOT   = 8'h2E,
    parameter logic [7:0] SEP_COLON = 8'h3A,
    parameter bit         SEND_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       auto_en,
    input  logic [6:0] digit_h,
    input  logic [6:0] digit_l,
    input  logic       dot,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       msg_done
);

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    localparam logic [2:0] LastIdx = SEND_CRLF ? 3'd6 : 3'd4;

    // Binary 0..99 to one ASCII digit; values above 99 clamp to 99.
    function automatic logic [7:0] digit_ascii(input logic [6:0] value, input logic want_tens);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = (value > 7'd99) ? 7'd99 : value;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return want_tens ? {4'h3, tens} : {4'h3, rem[3:0]};
    endfunction

    function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [6:0] h,
                                            input logic [6:0] l, input logic d);
        logic [7:0] b;
        case (idx)
            3'd0:    b = digit_ascii(h, 1'b1);
            3'd1:    b = digit_ascii(h, 1'b0);
            3'd2:    b = d ? SEP_DOT : SEP_COLON;
            3'd3:    b = digit_ascii(l, 1'b1);
            3'd4:    b = digit_ascii(l, 1'b0);
            3'd5:    b = 8'h0D;
            3'd6:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_e     state_q, state_d;
    logic       pending_q, pending_d;
    logic [2:0] idx_q, idx_d;
    logic [6:0] prev_l_q;
    logic [6:0] snap_h_q, snap_h_d;
    logic [6:0] snap_l_q, snap_l_d;
    logic       snap_dot_q, snap_dot_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       busy_q, busy_d;
    logic       msg_done_q, msg_done_d;
    logic       trig;

    always_comb begin
        trig       = req | (auto_en & (digit_l != prev_l_q));
        state_d    = state_q;
        pending_d  = pending_q;
        idx_d      = idx_q;
        snap_h_d   = snap_h_q;
        snap_l_d   = snap_l_q;
        snap_dot_d = snap_dot_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        msg_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (trig || pending_q) begin
                    // Byte 0 comes straight from the inputs; the snapshot is not registered yet.
                    snap_h_d   = digit_h;
                    snap_l_d   = digit_l;
                    snap_dot_d = dot;
                    pending_d  = 1'b0;
                    idx_d      = 3'd0;
                    tx_start_d = 1'b1;
                    tx_data_d  = msg_byte(3'd0, digit_h, digit_l, dot);
                    busy_d     = 1'b1;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (trig) pending_d = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (trig) pending_d = 1'b1;
                if (tx_done) begin
                    if (idx_q == LastIdx) begin
                        msg_done_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        tx_start_d = 1'b1;
                        tx_data_d  = msg_byte(idx_q + 3'd1, snap_h_q, snap_l_q, snap_dot_q);
                        state_d    = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            pending_q  <= 1'b0;
            idx_q      <= 3'd0;
            prev_l_q   <= 7'd0;
            snap_h_q   <= 7'd0;
            snap_l_q   <= 7'd0;
            snap_dot_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            msg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            prev_l_q   <= digit_l;
            snap_h_q   <= snap_h_d;
            snap_l_q   <= snap_l_d;
            snap_dot_q <= snap_dot_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            msg_done_q <= msg_done_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign msg_done = msg_done_q;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Directed bench for uart_time_reporter with a transmitter model that answers tx_done
// 10 cycles after each tx_start.
module tb_uart_time_reporter;

    logic       clk = 1'b0;
    logic       reset, req, auto_en, dot;
    logic [6:0] digit_h, digit_l;
    logic       tx_done = 1'b0;
    logic       tx_start, busy, msg_done;
    logic [7:0] tx_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_time_reporter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .auto_en  (auto_en),
        .digit_h  (digit_h),
        .digit_l  (digit_l),
        .dot      (dot),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .msg_done (msg_done)
    );

    // Transmitter model: tx_start seen in cycle S gives tx_done in cycle S+10.
    int cnt = 0;
    always @(posedge clk) begin
        #2;
        tx_done = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) tx_done = 1'b1;
        end
        if (tx_start) cnt = 10;
    end

    // Byte log plus tx_data stability and start/done pairing monitors.
    logic [7:0] q_data[$];
    int         q_cyc[$];
    int         stab_err = 0;
    int         dbl_err = 0;
    logic [7:0] last_data = 8'h00;
    bit         outstanding = 1'b0;
    logic       rst_prev = 1'b0;

    always @(negedge clk) begin
        if (tx_start) begin
            q_data.push_back(tx_data);
            q_cyc.push_back(cyc);
            if (outstanding) dbl_err++;
            outstanding = 1'b1;
        end else if (rst_prev && tx_data !== last_data) begin
            stab_err++;
        end
        if (tx_start || !rst_prev) last_data = tx_data;
        if (tx_done || !rst_prev) outstanding = 1'b0;
        rst_prev = reset;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step(1);
        req = 1'b0;
    endtask

    // Waits for msg_done; reports its cycle (-1 on timeout) and idle-busy cycles seen before it.
    task automatic wait_done(input int budget, output int at, output int gaps);
        at   = -1;
        gaps = 0;
        for (int i = 0; i < budget; i++) begin
            if (msg_done) begin
                at = cyc;
                break;
            end
            if (!busy) gaps++;
            step(1);
        end
    endtask

    task automatic check_msg(input string tag, input int base, input logic [7:0] exp_b[7]);
        for (int k = 0; k < 7; k++) begin
            logic [7:0] obs;
            obs = (base + k < q_data.size()) ? q_data[base+k] : 8'hxx;
            check($sformatf("%s_b%0d", tag, k), {24'h0, obs}, {24'h0, exp_b[k]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, at, gaps;
        reset = 1'b0; req = 1'b0; auto_en = 1'b0; dot = 1'b0;
        digit_h = 7'd12; digit_l = 7'd34;
        dot = 1'b1;
        step(3);
        check("rst_tx_start", {31'h0, tx_start}, 32'd0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h00);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_msg_done", {31'h0, msg_done}, 32'd0);
        reset = 1'b1;
        step(2);

        // Basic message 12.34 with CR LF
        q_data.delete(); q_cyc.delete();
        n = cyc;
        pulse_req();
        check("t1_start", {31'h0, tx_start}, 32'd1);
        check("t1_byte0", {24'h0, tx_data}, 32'h31);
        check("t1_busy", {31'h0, busy}, 32'd1);
        wait_done(200, at, gaps);
        check("t1_done_cycle", at, n + 78);
        check("t1_busy_gaps", gaps, 0);
        check("t1_busy_low", {31'h0, busy}, 32'd0);
        check("t1_count", q_data.size(), 7);
        check_msg("t1", 0, '{8'h31, 8'h32, 8'h2E, 8'h33, 8'h34, 8'h0D, 8'h0A});
        check("t1_last_start_cycle", (q_cyc.size() == 7) ? q_cyc[6] : -1, n + 67);
        step(1);
        check("t1_done_pulse", {31'h0, msg_done}, 32'd0);

        // Colon separator and clamp above 99
        digit_h = 7'd0; digit_l = 7'd105; dot = 1'b0;
        step(1);
        q_data.delete(); q_cyc.delete();
        pulse_req();
        wait_done(200, at, gaps);
        check("t2_done_seen", {31'h0, at >= 0}, 32'd1);
        check_msg("t2", 0, '{8'h30, 8'h30, 8'h3A, 8'h39, 8'h39, 8'h0D, 8'h0A});

        // Snapshot stability across input changes mid-message
        digit_h = 7'd12; digit_l = 7'd34; dot = 1'b1;
        step(1);
        q_data.delete(); q_cyc.delete();
        pulse_req();
        for (int i = 0; i < 100; i++) begin
            if (q_data.size() >= 2) break;
            step(1);
        end
        check("t3_two_bytes", {31'h0, q_data.size() >= 2}, 32'd1);
        digit_h = 7'd13; digit_l = 7'd56; dot = 1'b0;
        wait_done(200, at, gaps);
        check_msg("t3", 0, '{8'h31, 8'h32, 8'h2E, 8'h33, 8'h34, 8'h0D, 8'h0A});

        // Three requests while busy collapse to one extra message
        digit_h = 7'd21; digit_l = 7'd43; dot = 1'b0;
        step(1);
        q_data.delete(); q_cyc.delete();
        pulse_req();
        step(5);
        pulse_req();
        step(20);
        pulse_req();
        step(3);
        pulse_req();
        digit_h = 7'd7; digit_l = 7'd8; dot = 1'b1;
        wait_done(200, at, gaps);
        step(1);
        check("t4_restart", {31'h0, tx_start}, 32'd1);
        check("t4_restart_cycle", cyc, at + 1);
        wait_done(200, at, gaps);
        step(30);
        check("t4_count", q_data.size(), 14);
        check_msg("t4a", 0, '{8'h32, 8'h31, 8'h3A, 8'h34, 8'h33, 8'h0D, 8'h0A});
        check_msg("t4b", 7, '{8'h30, 8'h37, 8'h2E, 8'h30, 8'h38, 8'h0D, 8'h0A});

        // Request coincident with the final tx_done
        digit_h = 7'd3; digit_l = 7'd4; dot = 1'b0;
        step(1);
        q_data.delete(); q_cyc.delete();
        n = cyc;
        pulse_req();
        step(76);
        pulse_req();
        check("t5_msg_done", {31'h0, msg_done}, 32'd1);
        step(1);
        check("t5_restart", {31'h0, tx_start}, 32'd1);
        check("t5_restart_cycle", cyc, n + 79);
        wait_done(200, at, gaps);
        step(20);
        check("t5_count", q_data.size(), 14);

        // Auto mode: off ignores changes, on reports a change of digit_l
        q_data.delete(); q_cyc.delete();
        digit_l = 7'd5;
        step(2);
        digit_l = 7'd9;
        step(2);
        digit_l = 7'd5;
        step(20);
        check("t6_auto_off", q_data.size(), 0);
        digit_h = 7'd9; dot = 1'b0; auto_en = 1'b1;
        step(5);
        check("t6_auto_steady", q_data.size(), 0);
        digit_l = 7'd6;
        step(1);
        check("t6_auto_start", {31'h0, tx_start}, 32'd1);
        wait_done(200, at, gaps);
        step(20);
        auto_en = 1'b0;
        check("t6_count", q_data.size(), 7);
        check_msg("t6", 0, '{8'h30, 8'h39, 8'h3A, 8'h30, 8'h36, 8'h0D, 8'h0A});

        // Reset in WAIT after the third byte, with a request pending
        digit_h = 7'd12; digit_l = 7'd34; dot = 1'b1;
        step(1);
        q_data.delete(); q_cyc.delete();
        pulse_req();
        step(23);
        pulse_req();
        reset = 1'b0;
        step(1);
        check("t7_rst_tx_start", {31'h0, tx_start}, 32'd0);
        check("t7_rst_tx_data", {24'h0, tx_data}, 32'h00);
        check("t7_rst_busy", {31'h0, busy}, 32'd0);
        check("t7_rst_msg_done", {31'h0, msg_done}, 32'd0);
        reset = 1'b1;
        step(40);
        check("t7_no_resume", q_data.size(), 3);
        check("t7_idle_busy", {31'h0, busy}, 32'd0);
        pulse_req();
        check("t7_new_start", {31'h0, tx_start}, 32'd1);
        check("t7_new_byte0", {24'h0, tx_data}, 32'h31);
        wait_done(200, at, gaps);
        check("t7_new_done", {31'h0, at >= 0}, 32'd1);
        check("t7_count", q_data.size(), 10);

        check("tx_data_stable", stab_err, 0);
        check("start_without_done", dbl_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
